bus_uart_tx: RTL
================

BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter FifoDepth, default 8, TX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter BaudDivReset, default 16'd1084, reset value of BAUDDIV (cycles per bit minus 1; 125 MHz/115200).
REQ-003 SHALL have port clk_i  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  1  bus request from initiator.
REQ-006 SHALL have port we_i  input  1  write enable, qualified by req_i.
REQ-007 SHALL have port be_i  input  4  byte enables.
REQ-008 SHALL have port addr_i  input  32  byte address; only bits [3:2] decoded.
REQ-009 SHALL have port wdata_i  input  32  write data.
REQ-010 SHALL have port gnt_o  output  1  request granted.
REQ-011 SHALL have port rvalid_o  output  1  response valid.
REQ-012 SHALL have port rdata_o  output  32  read data, valid with rvalid_o.
REQ-013 SHALL have port err_o  output  1  error response, valid with rvalid_o.
REQ-014 SHALL have port tx_o  output  1  serial line, idle high.

Function
REQ-015 SHALL drive gnt_o = req_i combinationally; the block never stalls a request.
REQ-016 SHALL assert rvalid_o for exactly one cycle, one cycle after each granted request, reads and writes alike.
REQ-017 SHALL decode addr_i[3:2]: 0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 unmapped.
REQ-018 SHALL on an unmapped access ignore writes, return rdata_o=0 and assert err_o with rvalid_o.
REQ-019 SHALL on a TXDATA write with be_i[0]=1 push wdata_i[7:0] into the FIFO; be_i[0]=0 ignores the write; reads return 0.
REQ-020 SHALL accept a push when FIFO not full, or when full and a pop occurs the same cycle.
REQ-021 SHALL drop a rejected push and set sticky STATUS.overflow.
REQ-022 SHALL return STATUS = {28'b0, overflow, busy, empty, full} in bits [3:0]; a write with wdata_i[3]=1 and be_i[0]=1 clears overflow; overflow set and clear in the same cycle leaves overflow set.
REQ-023 SHALL read/write BAUDDIV in bits [15:0], honouring be_i[1:0] per byte; upper bits read 0.
REQ-024 SHALL use states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (popping one byte that cycle); START->DATA, DATA (8 bits)->STOP, each after one bit time; STOP->START if FIFO non-empty (pop), else IDLE.
REQ-025 SHALL define bit time as BAUDDIV+1 cycles via a down-counter reloaded at each bit boundary; a BAUDDIV write mid-frame takes effect at the next bit boundary.
REQ-026 SHALL transmit 8N1: tx_o=0 in START, data LSB first in DATA, tx_o=1 in STOP and IDLE; tx_o registered.
REQ-027 SHALL assert busy in every state except IDLE.
REQ-028 SHALL use a FIFO occupancy counter of width $clog2(FifoDepth)+1; pointers wrap modulo FifoDepth.

Reset
REQ-029 SHALL on rst_i=1 set rvalid_o=0, err_o=0, rdata_o=0, tx_o=1, state IDLE, FIFO empty, overflow=0, BAUDDIV=BaudDivReset, abandoning any frame in flight; gnt_o follows req_i.

Structure
REQ-030 SHALL place register offsets, STATUS bit indices and the state enum in package bus_uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module bus_uart_fifo (push/pop/full/empty/count).

Verification
REQ-032 SHALL cover: BAUDDIV=3, write TXDATA 0xA5 -> tx_o low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; rvalid_o one cycle after gnt_o.
REQ-033 SHALL cover: 9 back-to-back TXDATA writes while idle, FifoDepth=8 -> first byte popped, remaining 8 fit, no overflow; 10th write -> overflow=1, STATUS reads 0xD (overflow, busy, full).
REQ-034 SHALL cover: write STATUS 0x8 -> overflow cleared, next STATUS read bit3=0.
REQ-035 SHALL cover: read addr 0xC -> rvalid_o=1, err_o=1, rdata_o=0; write addr 0xC -> no state change.
REQ-036 SHALL cover: rst_i asserted mid-DATA -> next cycle tx_o=1, STATUS=0x2, BAUDDIV reads 1084.
REQ-037 SHALL cover: two queued bytes -> STOP followed directly by START, no idle bit between frames.

Source files
------------

// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus-attached UART transmitter: register map,
// STATUS bit positions and the transmit state encoding.
package bus_uart_pkg;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUDDIV  = 2'd2;
  localparam logic [1:0] REG_UNMAPPED = 2'd3;

  localparam int unsigned STATUS_FULL     = 0;
  localparam int unsigned STATUS_EMPTY    = 1;
  localparam int unsigned STATUS_BUSY     = 2;
  localparam int unsigned STATUS_OVERFLOW = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/bus_uart_fifo.sv
// Byte FIFO for the UART transmit path; power-of-two depth so the pointers
// wrap on their own. A push into a full FIFO is accepted only alongside a pop.
module bus_uart_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CountFull);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-attached 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers, a byte
// FIFO and the serialiser FSM.
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (line low) for one bit time
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (line high); chains straight into START if more queued
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter int unsigned FifoDepth    = 8,
  parameter logic [15:0] BaudDivReset = 16'd1084
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        tx_o
);

  logic [1:0]  reg_sel;
  logic        wr_txdata;
  logic        wr_ovf_clr;
  logic        wr_baud_lo;
  logic        wr_baud_hi;
  logic [15:0] baud_div;
  logic        overflow;
  logic        busy;
  logic [3:0]  status_bits;
  logic [31:0] rd_mux;

  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [7:0]                  fifo_rdata;
  logic [$clog2(FifoDepth):0]  fifo_count;
  logic                        push_rejected;

  tx_state_e   state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  bit_idx, bit_next;
  logic [7:0]  shift_q, shift_next;
  logic        tx_next;
  logic        bit_done;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], be_i[3:2], wdata_i[31:16], fifo_count};

  assign gnt_o   = req_i;
  assign reg_sel = addr_i[3:2];

  assign wr_txdata  = req_i & we_i & (reg_sel == REG_TXDATA) & be_i[0];
  assign wr_ovf_clr = req_i & we_i & (reg_sel == REG_STATUS) & be_i[0] & wdata_i[STATUS_OVERFLOW];
  assign wr_baud_lo = req_i & we_i & (reg_sel == REG_BAUDDIV) & be_i[0];
  assign wr_baud_hi = req_i & we_i & (reg_sel == REG_BAUDDIV) & be_i[1];

  assign push_rejected = wr_txdata & fifo_full & ~fifo_pop;
  assign busy          = (state != ST_IDLE);

  assign status_bits = {overflow, busy, fifo_empty, fifo_full};

  bus_uart_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .wdata (wdata_i[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_STATUS:  rd_mux[3:0]  = status_bits;
      REG_BAUDDIV: rd_mux[15:0] = baud_div;
      default:     rd_mux       = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
      overflow <= 1'b0;
      baud_div <= BaudDivReset;
    end else begin
      rvalid_o <= req_i;
      err_o    <= req_i & (reg_sel == REG_UNMAPPED);
      rdata_o  <= (req_i && !we_i) ? rd_mux : '0;
      // a rejected push wins over a clear landing in the same cycle
      if (push_rejected) begin
        overflow <= 1'b1;
      end else if (wr_ovf_clr) begin
        overflow <= 1'b0;
      end
      if (wr_baud_lo) baud_div[7:0]  <= wdata_i[7:0];
      if (wr_baud_hi) baud_div[15:8] <= wdata_i[15:8];
    end
  end

  assign bit_done = (cnt == 16'd0);

  // the bit-time reload reads baud_div live, so a new divisor applies at the next boundary
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift_q;
    tx_next    = tx_o;
    fifo_pop   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          cnt_next   = baud_div;
          state_next = ST_START;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next = ST_DATA;
          cnt_next   = baud_div;
          bit_next   = 3'd0;
          tx_next    = shift_q[0];
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_next = baud_div;
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift_q[7:1]};
            tx_next    = shift_q[1];
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_rdata;
            cnt_next   = baud_div;
            state_next = ST_START;
            tx_next    = 1'b0;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift_q <= shift_next;
      tx_o    <= tx_next;
    end
  end

endmodule
